// File: rtl/mmu_asid_pkg.sv
// Shared encodings for the ASID-aware MMU: memory opcodes, exception codes,
// TLB entry field layout and the load extension helper.
package mmu_asid_pkg;

    localparam int MEM_OPT_WIDTH = 4;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_NONE = 4'd0;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_LW   = 4'd1;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_LBS  = 4'd2;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_LBU  = 4'd3;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_LHS  = 4'd4;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_LHU  = 4'd5;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_SW   = 4'd6;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_SH   = 4'd7;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_SB   = 4'd8;

    localparam int EXC_CODE_WIDTH = 5;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_NONE    = 5'd0;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_TLB_MOD = 5'd1;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_TLBL    = 5'd2;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_TLBS    = 5'd3;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_ADEL    = 5'd4;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_ADES    = 5'd5;

    // Entry layout, LSB first: v0, d0, pfn0, v1, d1, pfn1, g, asid, vpn2
    localparam int VPN2_WIDTH   = 19;
    localparam int TLB_OFF_V0   = 0;
    localparam int TLB_OFF_D0   = 1;
    localparam int TLB_OFF_PFN0 = 2;

    function automatic int tlb_off_v1(input int pfn_w);
        return 2 + pfn_w;
    endfunction

    function automatic int tlb_off_d1(input int pfn_w);
        return 3 + pfn_w;
    endfunction

    function automatic int tlb_off_pfn1(input int pfn_w);
        return 4 + pfn_w;
    endfunction

    function automatic int tlb_off_g(input int pfn_w);
        return 4 + 2 * pfn_w;
    endfunction

    function automatic int tlb_off_asid(input int pfn_w);
        return 5 + 2 * pfn_w;
    endfunction

    function automatic int tlb_off_vpn2(input int asid_w, input int pfn_w);
        return 5 + 2 * pfn_w + asid_w;
    endfunction

    function automatic int tlb_entry_width(input int asid_w, input int pfn_w);
        return 5 + 2 * pfn_w + asid_w + VPN2_WIDTH;
    endfunction

    function automatic logic [31:0] load_extend(input logic [MEM_OPT_WIDTH-1:0] opt,
                                                input logic [1:0] off,
                                                input logic [31:0] word);
        logic [31:0] byte_sh;
        logic [31:0] half_sh;
        byte_sh = word >> {off, 3'b000};
        half_sh = word >> {off[1], 4'b0000};
        case (opt)
            MEM_OPT_LBS: return {{24{byte_sh[7]}}, byte_sh[7:0]};
            MEM_OPT_LBU: return {24'd0, byte_sh[7:0]};
            MEM_OPT_LHS: return {{16{half_sh[15]}}, half_sh[15:0]};
            MEM_OPT_LHU: return {16'd0, half_sh[15:0]};
            default:     return word;
        endcase
    endfunction

endpackage

// File: rtl/mmu_asid_tlb_lookup.sv
// Fully associative TLB match with a lowest-index-wins priority encoder.
module tlb_lookup
    import mmu_asid_pkg::*;
#(
    parameter int NR_TLB     = 16,
    parameter int ASID_WIDTH = 8,
    localparam int IDX_W     = $clog2(NR_TLB)
) (
    input  logic [VPN2_WIDTH-1:0]               key_vpn2,
    input  logic [ASID_WIDTH-1:0]               key_asid,
    input  logic [NR_TLB-1:0][VPN2_WIDTH-1:0]   entry_vpn2,
    input  logic [NR_TLB-1:0][ASID_WIDTH-1:0]   entry_asid,
    input  logic [NR_TLB-1:0]                   entry_g,
    input  logic [NR_TLB-1:0]                   entry_valid,
    output logic                                hit,
    output logic [IDX_W-1:0]                    index
);

    always_comb begin
        hit   = 1'b0;
        index = '0;
        for (int i = NR_TLB - 1; i >= 0; i--) begin
            if (entry_valid[i] && entry_vpn2[i] == key_vpn2 &&
                (entry_g[i] || entry_asid[i] == key_asid)) begin
                hit   = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mmu_asid.sv
// ASID-tagged MMU: TLB/direct translation, exception priority and a small
// read-merge-write FSM for sub-word stores.
module mmu_asid
    import mmu_asid_pkg::*;
#(
    parameter int NR_TLB      = 16,
    parameter int ASID_WIDTH  = 8,
    parameter int PADDR_WIDTH = 32,
    localparam int IDX_W       = $clog2(NR_TLB),
    localparam int PFN_W       = PADDR_WIDTH - 12,
    localparam int TLB_ENTRY_W = tlb_entry_width(ASID_WIDTH, PFN_W)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tlb_we,
    input  logic [IDX_W-1:0]          tlb_index,
    input  logic [TLB_ENTRY_W-1:0]    tlb_entry,
    input  logic [ASID_WIDTH-1:0]     cur_asid,
    input  logic                      user_mode,
    input  logic [VPN2_WIDTH-1:0]     probe_vpn2,
    input  logic [ASID_WIDTH-1:0]     probe_asid,
    output logic                      probe_hit,
    output logic [IDX_W-1:0]          probe_index,
    input  logic [31:0]               instr_addr,
    output logic [31:0]               instr_out,
    input  logic [MEM_OPT_WIDTH-1:0]  data_opt,
    input  logic [31:0]               data_addr,
    input  logic [31:0]               data_in,
    output logic [31:0]               data_out,
    output logic                      busy,
    output logic [EXC_CODE_WIDTH-1:0] exc_code,
    output logic [PADDR_WIDTH-1:0]    dev_mem_addr,
    output logic [31:0]               dev_mem_data_out,
    output logic                      dev_mem_is_write,
    input  logic [31:0]               dev_mem_data_in,
    input  logic                      dev_mem_busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MERGE = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [NR_TLB-1:0][VPN2_WIDTH-1:0] tlb_vpn2;
    logic [NR_TLB-1:0][ASID_WIDTH-1:0] tlb_asid;
    logic [NR_TLB-1:0][PFN_W-1:0]      tlb_pfn0;
    logic [NR_TLB-1:0][PFN_W-1:0]      tlb_pfn1;
    logic [NR_TLB-1:0]                 tlb_g;
    logic [NR_TLB-1:0]                 tlb_v0;
    logic [NR_TLB-1:0]                 tlb_v1;
    logic [NR_TLB-1:0]                 tlb_d0;
    logic [NR_TLB-1:0]                 tlb_d1;

    logic [1:0]               state;
    logic [PADDR_WIDTH-1:0]   lat_paddr;
    logic [1:0]               lat_off;
    logic [MEM_OPT_WIDTH-1:0] lat_op;
    logic [31:0]              wdata;
    logic [31:0]              merge_word;

    logic [31:0]              vaddr;
    logic [MEM_OPT_WIDTH-1:0] req_op;
    logic                     is_store;
    logic                     misalign;
    logic                     unmapped;
    logic                     acc_hit;
    logic [IDX_W-1:0]         acc_index;
    logic                     sel_dirty;
    logic [PADDR_WIDTH-1:0]   paddr;
    logic [EXC_CODE_WIDTH-1:0] exc_idle;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tlb_vpn2 <= '0;
            tlb_asid <= '0;
            tlb_pfn0 <= '0;
            tlb_pfn1 <= '0;
            tlb_g    <= '0;
            tlb_v0   <= '0;
            tlb_v1   <= '0;
            tlb_d0   <= '0;
            tlb_d1   <= '0;
        end else if (tlb_we) begin
            tlb_vpn2[tlb_index] <= tlb_entry[tlb_off_vpn2(ASID_WIDTH, PFN_W) +: VPN2_WIDTH];
            tlb_asid[tlb_index] <= tlb_entry[tlb_off_asid(PFN_W) +: ASID_WIDTH];
            tlb_g[tlb_index]    <= tlb_entry[tlb_off_g(PFN_W)];
            tlb_pfn1[tlb_index] <= tlb_entry[tlb_off_pfn1(PFN_W) +: PFN_W];
            tlb_d1[tlb_index]   <= tlb_entry[tlb_off_d1(PFN_W)];
            tlb_v1[tlb_index]   <= tlb_entry[tlb_off_v1(PFN_W)];
            tlb_pfn0[tlb_index] <= tlb_entry[TLB_OFF_PFN0 +: PFN_W];
            tlb_d0[tlb_index]   <= tlb_entry[TLB_OFF_D0];
            tlb_v0[tlb_index]   <= tlb_entry[TLB_OFF_V0];
        end
    end

    assign vaddr  = (data_opt == MEM_OPT_NONE) ? instr_addr : data_addr;
    assign req_op = (data_opt == MEM_OPT_NONE) ? MEM_OPT_LW : data_opt;

    tlb_lookup #(
        .NR_TLB     (NR_TLB),
        .ASID_WIDTH (ASID_WIDTH)
    ) u_access_lookup (
        .key_vpn2    (vaddr[31:13]),
        .key_asid    (cur_asid),
        .entry_vpn2  (tlb_vpn2),
        .entry_asid  (tlb_asid),
        .entry_g     (tlb_g),
        .entry_valid (vaddr[12] ? tlb_v1 : tlb_v0),
        .hit         (acc_hit),
        .index       (acc_index)
    );

    // Probe treats an entry with neither page valid as empty
    tlb_lookup #(
        .NR_TLB     (NR_TLB),
        .ASID_WIDTH (ASID_WIDTH)
    ) u_probe_lookup (
        .key_vpn2    (probe_vpn2),
        .key_asid    (probe_asid),
        .entry_vpn2  (tlb_vpn2),
        .entry_asid  (tlb_asid),
        .entry_g     (tlb_g),
        .entry_valid (tlb_v0 | tlb_v1),
        .hit         (probe_hit),
        .index       (probe_index)
    );

    always_comb begin
        is_store  = (req_op == MEM_OPT_SW) || (req_op == MEM_OPT_SH) || (req_op == MEM_OPT_SB);
        misalign  = (((req_op == MEM_OPT_LW) || (req_op == MEM_OPT_SW)) && vaddr[1:0] != 2'b00) ||
                    (((req_op == MEM_OPT_LHS) || (req_op == MEM_OPT_LHU) || (req_op == MEM_OPT_SH)) &&
                     vaddr[0]);
        unmapped  = (vaddr[31:30] == 2'b10);
        sel_dirty = vaddr[12] ? tlb_d1[acc_index] : tlb_d0[acc_index];
        if (unmapped) begin
            paddr = PADDR_WIDTH'(vaddr[28:0]);
        end else begin
            paddr = {(vaddr[12] ? tlb_pfn1[acc_index] : tlb_pfn0[acc_index]), vaddr[11:0]};
        end
        if (misalign || (user_mode && vaddr[31])) begin
            exc_idle = is_store ? EC_ADES : EC_ADEL;
        end else if (!unmapped && !acc_hit) begin
            exc_idle = is_store ? EC_TLBS : EC_TLBL;
        end else if (!unmapped && is_store && !sel_dirty) begin
            exc_idle = EC_TLB_MOD;
        end else begin
            exc_idle = EC_NONE;
        end
    end

    assign exc_code         = (state == S_IDLE) ? exc_idle : EC_NONE;
    assign busy             = ((state != S_IDLE) || dev_mem_busy || (state == S_IDLE && is_store)) &&
                              (exc_code == EC_NONE);
    assign dev_mem_addr     = (state == S_IDLE) ? paddr : lat_paddr;
    assign dev_mem_data_out = wdata;
    assign dev_mem_is_write = (state == S_WRITE);
    assign instr_out        = dev_mem_data_in;
    assign data_out         = load_extend(data_opt, vaddr[1:0], dev_mem_data_in);

    always_comb begin
        merge_word = dev_mem_data_in;
        if (lat_op == MEM_OPT_SB) begin
            case (lat_off)
                2'd0:    merge_word[7:0]   = wdata[7:0];
                2'd1:    merge_word[15:8]  = wdata[7:0];
                2'd2:    merge_word[23:16] = wdata[7:0];
                default: merge_word[31:24] = wdata[7:0];
            endcase
        end else if (lat_off[1]) begin
            merge_word[31:16] = wdata[15:0];
        end else begin
            merge_word[15:0] = wdata[15:0];
        end
    end

    // wdata holds the raw store data until MERGE folds it into the read word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            lat_paddr <= '0;
            lat_off   <= '0;
            lat_op    <= MEM_OPT_NONE;
            wdata     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_store && exc_idle == EC_NONE && !dev_mem_busy) begin
                        lat_paddr <= paddr;
                        lat_off   <= vaddr[1:0];
                        lat_op    <= data_opt;
                        wdata     <= data_in;
                        state     <= (data_opt == MEM_OPT_SW) ? S_WRITE : S_MERGE;
                    end
                end
                S_MERGE: begin
                    if (!dev_mem_busy) begin
                        wdata <= merge_word;
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!dev_mem_busy) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_asid.sv
// Directed self-checking bench for mmu_asid with hand-computed expectations.
module tb_mmu_asid;
    import mmu_asid_pkg::*;

    logic        clk;
    logic        rst;
    logic        tlb_we;
    logic [3:0]  tlb_index;
    logic [71:0] tlb_entry;
    logic [7:0]  cur_asid;
    logic        user_mode;
    logic [18:0] probe_vpn2;
    logic [7:0]  probe_asid;
    logic        probe_hit;
    logic [3:0]  probe_index;
    logic [31:0] instr_addr;
    logic [31:0] instr_out;
    logic [3:0]  data_opt;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        busy;
    logic [4:0]  exc_code;
    logic [31:0] dev_mem_addr;
    logic [31:0] dev_mem_data_out;
    logic        dev_mem_is_write;
    logic [31:0] dev_mem_data_in;
    logic        dev_mem_busy;

    int checks;
    int failures;

    mmu_asid dut (
        .clk              (clk),
        .rst              (rst),
        .tlb_we           (tlb_we),
        .tlb_index        (tlb_index),
        .tlb_entry        (tlb_entry),
        .cur_asid         (cur_asid),
        .user_mode        (user_mode),
        .probe_vpn2       (probe_vpn2),
        .probe_asid       (probe_asid),
        .probe_hit        (probe_hit),
        .probe_index      (probe_index),
        .instr_addr       (instr_addr),
        .instr_out        (instr_out),
        .data_opt         (data_opt),
        .data_addr        (data_addr),
        .data_in          (data_in),
        .data_out         (data_out),
        .busy             (busy),
        .exc_code         (exc_code),
        .dev_mem_addr     (dev_mem_addr),
        .dev_mem_data_out (dev_mem_data_out),
        .dev_mem_is_write (dev_mem_is_write),
        .dev_mem_data_in  (dev_mem_data_in),
        .dev_mem_busy     (dev_mem_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] din);
        data_opt  = op;
        data_addr = addr;
        data_in   = din;
        #1;
    endtask

    function automatic logic [71:0] makeEntry(input logic [18:0] vpn2, input logic [7:0] asid,
                                              input logic g, input logic [19:0] pfn1,
                                              input logic d1, input logic v1,
                                              input logic [19:0] pfn0, input logic d0,
                                              input logic v0);
        return {vpn2, asid, g, pfn1, d1, v1, pfn0, d0, v0};
    endfunction

    task automatic writeTlb(input logic [3:0] idx, input logic [71:0] entry);
        tlb_we    = 1'b1;
        tlb_index = idx;
        tlb_entry = entry;
        tick();
        tlb_we    = 1'b0;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b0;
        tlb_we          = 1'b0;
        tlb_index       = '0;
        tlb_entry       = '0;
        cur_asid        = 8'd0;
        user_mode       = 1'b0;
        probe_vpn2      = '0;
        probe_asid      = '0;
        instr_addr      = 32'hBFC0_0010;
        data_opt        = MEM_OPT_NONE;
        data_addr       = '0;
        data_in         = '0;
        dev_mem_data_in = '0;
        dev_mem_busy    = 1'b0;

        // A TLB write attempted under reset must be dropped
        tlb_we    = 1'b1;
        tlb_index = 4'd0;
        tlb_entry = makeEntry(19'h00050, 8'd0, 1'b0, 20'h0, 1'b0, 1'b0, 20'h00777, 1'b1, 1'b1);
        tick();
        tick();
        tlb_we = 1'b0;
        checkOutput("rst_is_write", 32'(dev_mem_is_write), 32'd0);
        checkOutput("rst_data_out", dev_mem_data_out, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_exc", 32'(exc_code), 32'(EC_NONE));
        rst = 1'b1;
        probe_vpn2 = 19'h00050;
        probe_asid = 8'd0;
        #1;
        checkOutput("rst_tlb_we_ignored", 32'(probe_hit), 32'd0);

        checkOutput("fetch_addr", dev_mem_addr, 32'h1FC0_0010);
        dev_mem_data_in = 32'h2402_0001;
        #1;
        checkOutput("fetch_word", instr_out, 32'h2402_0001);

        dev_mem_data_in = 32'hDEAD_BEEF;
        applyStimulus(MEM_OPT_LW, 32'h8000_1004, 32'd0);
        checkOutput("lw_kseg0_addr", dev_mem_addr, 32'h0000_1004);
        checkOutput("lw_kseg0_data", data_out, 32'hDEAD_BEEF);
        checkOutput("lw_kseg0_busy", 32'(busy), 32'd0);
        checkOutput("lw_kseg0_exc", 32'(exc_code), 32'(EC_NONE));

        dev_mem_data_in = 32'h8822_3384;
        applyStimulus(MEM_OPT_LBS, 32'h8000_0000, 32'd0);
        checkOutput("lbs_off0", data_out, 32'hFFFF_FF84);
        applyStimulus(MEM_OPT_LBS, 32'h8000_0001, 32'd0);
        checkOutput("lbs_off1", data_out, 32'h0000_0033);
        applyStimulus(MEM_OPT_LBU, 32'h8000_0000, 32'd0);
        checkOutput("lbu_off0", data_out, 32'h0000_0084);
        applyStimulus(MEM_OPT_LHS, 32'h8000_0002, 32'd0);
        checkOutput("lhs_off2", data_out, 32'hFFFF_8822);
        applyStimulus(MEM_OPT_LHU, 32'h8000_0002, 32'd0);
        checkOutput("lhu_off2", data_out, 32'h0000_8822);

        writeTlb(4'd2, makeEntry(19'h00010, 8'd5, 1'b0, 20'h0, 1'b0, 1'b0, 20'h00123, 1'b1, 1'b1));
        cur_asid = 8'd5;
        applyStimulus(MEM_OPT_LW, 32'h0002_0008, 32'd0);
        checkOutput("tlb_hit_addr", dev_mem_addr, 32'h0012_3008);
        checkOutput("tlb_hit_exc", 32'(exc_code), 32'(EC_NONE));
        cur_asid = 8'd6;
        #1;
        checkOutput("tlb_asid_miss", 32'(exc_code), 32'(EC_TLBL));
        checkOutput("tlb_asid_miss_busy", 32'(busy), 32'd0);
        cur_asid = 8'd5;
        applyStimulus(MEM_OPT_LW, 32'h0002_1000, 32'd0);
        checkOutput("tlb_odd_invalid", 32'(exc_code), 32'(EC_TLBL));
        applyStimulus(MEM_OPT_SW, 32'h0002_1000, 32'd0);
        checkOutput("tlb_store_invalid", 32'(exc_code), 32'(EC_TLBS));

        applyStimulus(MEM_OPT_SH, 32'h8000_0001, 32'h0000_1234);
        checkOutput("sh_misalign", 32'(exc_code), 32'(EC_ADES));
        checkOutput("sh_misalign_busy", 32'(busy), 32'd0);
        tick();
        checkOutput("sh_misalign_nowrite", 32'(dev_mem_is_write), 32'd0);
        applyStimulus(MEM_OPT_LW, 32'h8000_0002, 32'd0);
        checkOutput("lw_misalign", 32'(exc_code), 32'(EC_ADEL));
        user_mode = 1'b1;
        applyStimulus(MEM_OPT_LW, 32'h8000_0000, 32'd0);
        checkOutput("user_kseg", 32'(exc_code), 32'(EC_ADEL));
        user_mode = 1'b0;

        writeTlb(4'd1, makeEntry(19'h00020, 8'd5, 1'b0, 20'h0, 1'b0, 1'b0, 20'h00456, 1'b0, 1'b1));
        applyStimulus(MEM_OPT_SW, 32'h0004_0000, 32'h1);
        checkOutput("sw_tlb_mod", 32'(exc_code), 32'(EC_TLB_MOD));
        checkOutput("sw_tlb_mod_busy", 32'(busy), 32'd0);
        applyStimulus(MEM_OPT_NONE, 32'd0, 32'd0);

        writeTlb(4'd7, makeEntry(19'h00030, 8'd9, 1'b0, 20'h0, 1'b0, 1'b0, 20'h00999, 1'b1, 1'b1));
        probe_vpn2 = 19'h00030;
        probe_asid = 8'd9;
        tlb_we     = 1'b1;
        tlb_index  = 4'd3;
        tlb_entry  = makeEntry(19'h00030, 8'd9, 1'b0, 20'h0, 1'b0, 1'b0, 20'h00333, 1'b1, 1'b1);
        #1;
        checkOutput("probe_prewrite", 32'(probe_index), 32'd7);
        tick();
        tlb_we = 1'b0;
        checkOutput("probe_hit", 32'(probe_hit), 32'd1);
        checkOutput("probe_lowest", 32'(probe_index), 32'd3);
        probe_asid = 8'd10;
        #1;
        checkOutput("probe_miss", 32'(probe_hit), 32'd0);

        dev_mem_data_in = 32'h1122_3344;
        applyStimulus(MEM_OPT_SB, 32'h8000_0102, 32'h0000_00AB);
        checkOutput("sb_idle_busy", 32'(busy), 32'd1);
        checkOutput("sb_idle_addr", dev_mem_addr, 32'h0000_0102);
        tick();
        applyStimulus(MEM_OPT_NONE, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkOutput("sb_merge_busy", 32'(busy), 32'd1);
        checkOutput("sb_merge_nowrite", 32'(dev_mem_is_write), 32'd0);
        checkOutput("sb_merge_addr", dev_mem_addr, 32'h0000_0102);
        tick();
        checkOutput("sb_write_strobe", 32'(dev_mem_is_write), 32'd1);
        checkOutput("sb_write_data", dev_mem_data_out, 32'h11AB_3344);
        checkOutput("sb_write_busy", 32'(busy), 32'd1);
        tick();
        checkOutput("sb_done_busy", 32'(busy), 32'd0);
        checkOutput("sb_done_nowrite", 32'(dev_mem_is_write), 32'd0);

        applyStimulus(MEM_OPT_SH, 32'h8000_0202, 32'h1234_BEEF);
        tick();
        applyStimulus(MEM_OPT_NONE, 32'd0, 32'd0);
        tick();
        checkOutput("sh_write_data", dev_mem_data_out, 32'hBEEF_3344);
        tick();

        applyStimulus(MEM_OPT_SW, 32'h8000_0300, 32'hCAFE_F00D);
        tick();
        applyStimulus(MEM_OPT_NONE, 32'd0, 32'd0);
        dev_mem_busy = 1'b1;
        #1;
        checkOutput("sw_write_strobe", 32'(dev_mem_is_write), 32'd1);
        checkOutput("sw_write_data", dev_mem_data_out, 32'hCAFE_F00D);
        tick();
        checkOutput("sw_hold1", 32'(dev_mem_is_write), 32'd1);
        tick();
        dev_mem_busy = 1'b0;
        #1;
        checkOutput("sw_hold2", 32'(dev_mem_is_write), 32'd1);
        checkOutput("sw_hold2_addr", dev_mem_addr, 32'h0000_0300);
        tick();
        checkOutput("sw_done", 32'(dev_mem_is_write), 32'd0);
        checkOutput("sw_done_busy", 32'(busy), 32'd0);

        applyStimulus(MEM_OPT_SB, 32'h8000_0400, 32'h0000_0055);
        tick();
        applyStimulus(MEM_OPT_NONE, 32'd0, 32'd0);
        checkOutput("rst_mid_merge_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_data_out", dev_mem_data_out, 32'd0);
        checkOutput("rst_mid_idle_addr", dev_mem_addr, 32'h1FC0_0010);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rst_mid_nowrite", 32'(dev_mem_is_write), 32'd0);
        end
        applyStimulus(MEM_OPT_LW, 32'h0002_0008, 32'd0);
        checkOutput("rst_tlb_cleared", 32'(exc_code), 32'(EC_TLBL));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmu_asid.md
MMU_ASID -- requirements
Module: mmu_asid

Interface
REQ-001 SHALL have parameter NR_TLB, default 16, TLB entry count (power of two, 2..64).
REQ-002 SHALL have parameter ASID_WIDTH, default 8, address-space identifier width.
REQ-003 SHALL have parameter PADDR_WIDTH, default 32, physical address width (29..32).
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port tlb_we / tlb_index  in  1 / log2(NR_TLB)  TLB write strobe and slot.
REQ-007 SHALL have port tlb_entry  in  TLB_ENTRY_W  {vpn2[18:0], asid, g, pfn1, d1, v1, pfn0, d0, v0}.
REQ-008 SHALL have port cur_asid / user_mode  in  ASID_WIDTH / 1  current address space and privilege.
REQ-009 SHALL have port probe_vpn2 / probe_asid  in  19 / ASID_WIDTH  TLBP lookup key.
REQ-010 SHALL have port probe_hit / probe_index  out  1 / log2(NR_TLB)  TLBP result, combinational.
REQ-011 SHALL have port instr_addr / instr_out  in / out  32 / 32  fetch address and fetched word.
REQ-012 SHALL have port data_opt / data_addr / data_in  in  MEM_OPT_WIDTH / 32 / 32  data request.
REQ-013 SHALL have port data_out / busy / exc_code  out  32 / 1 / EXC_CODE_WIDTH  load result, stall, exception.
REQ-014 SHALL have port dev_mem_addr / dev_mem_data_out / dev_mem_is_write  out  PADDR_WIDTH / 32 / 1  physical memory side.
REQ-015 SHALL have port dev_mem_data_in / dev_mem_busy  in  32 / 1  memory read data, memory stall.

Function
REQ-016 SHALL decode data_opt NONE, LW, LBS, LBU, LHS, LHU, SW, SH, SB; NONE in IDLE selects instr_addr.
REQ-017 SHALL map 0x80000000-0xBFFFFFFF directly (paddr = vaddr[28:0] zero-extended), kernel mode only.
REQ-018 SHALL hit entry i iff vpn2 matches vaddr[31:13], (g or asid==cur_asid), and v0/v1 set per vaddr[12].
REQ-019 SHALL resolve multiple hits to the lowest index; translation and probe combinational.
REQ-020 SHALL report exc_code by priority: ADEL/ADES (misalign word/half, or user_mode access to vaddr[31]=1) > TLBL/TLBS (miss or invalid) > TLB_MOD (store, d bit clear) > NONE.
REQ-021 SHALL, on exc_code != NONE, perform no memory access, keep busy low, and not change state.
REQ-022 SHALL run FSM states IDLE, MERGE, WRITE: SW IDLE->WRITE; SB/SH IDLE->MERGE->WRITE; WRITE->IDLE.
REQ-023 SHALL leave IDLE only when dev_mem_busy is low; hold MERGE/WRITE while dev_mem_busy is high.
REQ-024 SHALL latch physical address, byte offset, opcode and data_in on leaving IDLE; later cycles ignore data_addr/data_in.
REQ-025 SHALL in MERGE read the latched word and replace byte (SB) or halfword (SH, offset[1]) with data_in low bits.
REQ-026 SHALL assert dev_mem_is_write only in WRITE; busy = (state!=IDLE or dev_mem_busy or store request) and exc_code==NONE.
REQ-027 SHALL drive loads combinationally from dev_mem_data_in, LBS/LHS sign-extended, LBU/LHU zero-extended; valid when busy low.
REQ-028 SHALL let lookups in the tlb_we cycle see pre-write contents; write visible next cycle.
REQ-029 SHALL ignore tlb_we while rst is asserted.

Reset
REQ-030 SHALL on rst low immediately set state IDLE, all v0/v1 = 0, dev_mem_data_out = 0, dev_mem_is_write = 0.
REQ-031 SHALL abandon any in-flight store on reset mid-operation with no write issued afterwards.

Structure
REQ-032 SHALL take MEM_OPT_* and EC_* codes, MEM_OPT_WIDTH, EXC_CODE_WIDTH and TLB entry field offsets from the shared package.
REQ-033 SHALL place the entry match and priority encoder in sub-module tlb_lookup (instantiated twice: access and probe).

Verification
REQ-034 SHALL test: reset, LW 0x80001004 -> dev_mem_addr 0x00001004, data_out = dev_mem_data_in, busy 0.
REQ-035 SHALL test: entry vpn2=0x00010, asid 5, g 0, pfn0 0x00123, v0=d0=1; cur_asid 5 LW 0x00020008 -> addr 0x00123008; cur_asid 6 -> TLBL.
REQ-036 SHALL test: memory word 0x11223344, SB 0xAB at offset 2 -> write 0x11AB3344 after IDLE->MERGE->WRITE, busy 3 cycles.
REQ-037 SHALL test: SH to 0x80000001 -> ADES, no write; user_mode LW 0x80000000 -> ADEL.
REQ-038 SHALL test: d0=0 SW -> TLB_MOD; entries 3 and 7 same key -> probe_index 3, probe_hit 1.
REQ-039 SHALL test: dev_mem_busy high 2 cycles during WRITE, rst low mid-MERGE -> no write, state IDLE.
